// File: rtl/prc_pkg.sv
// Shared types and constants for the LCD framebuffer copier.
//   copier_state_t      : sequencer states
//   LCD_CMD_*           : LCD controller command opcodes (low bits ORed in by the user)
//   LCD_*_ADDR_DFLT     : default bus addresses of the LCD command/data registers
package prc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StCmdPage,
        StCmdColLo,
        StCmdColHi,
        StRd,
        StWr,
        StDone
    } copier_state_t;

    localparam logic [7:0] LCD_CMD_SET_PAGE = 8'hB0;
    localparam logic [7:0] LCD_CMD_COL_LO   = 8'h00;
    localparam logic [7:0] LCD_CMD_COL_HI   = 8'h10;

    localparam logic [23:0] LCD_CMD_ADDR_DFLT  = 24'h0020FE;
    localparam logic [23:0] LCD_DATA_ADDR_DFLT = 24'h0020FF;

endpackage

// File: rtl/bus_strobe_gen.sv
// Two-phase bus operation generator: one ASSERT ce cycle (exactly one strobe high) followed by
// one RELEASE ce cycle (strobes low, address/data held). The grant is only consulted when an
// ASSERT is about to start; without it the operation waits with strobes low.
//   clk_i/ce_i/rst_i : clock, clock enable, synchronous active-high reset
//   req_i, wr_i      : operation pending, kind (1 = write, 0 = read)
//   addr_i, wdata_i  : operation address and write data
//   grant_i          : bus grant
//   assert_o         : current ce cycle is the ASSERT phase
//   ack_o            : current ce cycle is the RELEASE phase (operation completes at its end)
//   bus_*_o, addr_o, wdata_o : bus signals
module bus_strobe_gen (
    input  logic        clk_i,
    input  logic        ce_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [23:0] addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        grant_i,
    output logic        assert_o,
    output logic        ack_o,
    output logic        bus_write_o,
    output logic        bus_read_o,
    output logic [23:0] addr_o,
    output logic [7:0]  wdata_o
);

    logic release_q, release_d;

    always_comb begin
        assert_o  = req_i && !release_q && grant_i;
        ack_o     = release_q;
        release_d = release_q;
        if (assert_o) begin
            release_d = 1'b1;
        end else if (release_q) begin
            release_d = 1'b0;
        end
        bus_write_o = assert_o && wr_i;
        bus_read_o  = assert_o && !wr_i;
        addr_o      = req_i ? addr_i : 24'h000000;
        wdata_o     = (req_i && wr_i) ? wdata_i : 8'h00;
    end

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (rst_i) begin
                release_q <= 1'b0;
            end else begin
                release_q <= release_d;
            end
        end
    end

endmodule

// File: rtl/prc_lcd_copier.sv
// Bus-master sequencer copying a PAGES x COLUMNS 1bpp framebuffer from RAM into LCD memory.
// Per page: set-page, column-low, column-high commands, then COLUMNS read/write pairs.
//   clk, reset, clk_ce : clock, synchronous active-high reset, clock enable
//   start              : level, accepted only in IDLE
//   bus_grant / bus_request : arbiter handshake
//   bus_write, bus_read, address_out, data_out, data_in : system bus
//   busy               : high from accepted start through DONE
//   done               : one ce-cycle pulse at end of frame
module prc_lcd_copier
    import prc_pkg::*;
#(
    parameter logic [23:0] FB_BASE       = 24'h001000,
    parameter logic [23:0] LCD_CMD_ADDR  = LCD_CMD_ADDR_DFLT,
    parameter logic [23:0] LCD_DATA_ADDR = LCD_DATA_ADDR_DFLT,
    parameter int unsigned COLUMNS       = 96,
    parameter int unsigned PAGES         = 8,
    parameter int unsigned COL_OFFSET    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        start,
    input  logic        bus_grant,
    output logic        bus_request,
    output logic        bus_write,
    output logic        bus_read,
    output logic [23:0] address_out,
    output logic [7:0]  data_out,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LastCol  = 8'(COLUMNS - 1);
    localparam logic [2:0] LastPage = 3'(PAGES - 1);
    localparam logic [7:0] ColOff   = 8'(COL_OFFSET);

    copier_state_t state_q, state_d;
    logic [2:0]    page_q, page_d;
    logic [7:0]    col_q, col_d;
    logic [7:0]    byte_q;

    logic          op_req, op_wr, op_ack, op_assert;
    logic [23:0]   op_addr;
    logic [7:0]    op_data;
    logic [15:0]   fb_off;

    // Operation decode: address and data are pure functions of state, so they stay stable
    // across ASSERT and RELEASE and across any grant wait.
    always_comb begin
        fb_off  = 16'(page_q) * 16'(COLUMNS) + 16'(col_q);
        op_req  = 1'b1;
        op_wr   = 1'b1;
        op_addr = LCD_CMD_ADDR;
        op_data = 8'h00;
        case (state_q)
            StCmdPage:  op_data = LCD_CMD_SET_PAGE | {5'b00000, page_q};
            StCmdColLo: op_data = LCD_CMD_COL_LO | {4'h0, ColOff[3:0]};
            StCmdColHi: op_data = LCD_CMD_COL_HI | {4'h0, ColOff[7:4]};
            StRd: begin
                op_wr   = 1'b0;
                op_addr = FB_BASE + {8'h00, fb_off};
            end
            StWr: begin
                op_addr = LCD_DATA_ADDR;
                op_data = byte_q;
            end
            default: begin
                op_req  = 1'b0;
                op_addr = 24'h000000;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        col_d   = col_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    page_d  = 3'd0;
                    col_d   = 8'd0;
                end
            end
            StReq:      if (bus_grant) state_d = StCmdPage;
            StCmdPage:  if (op_ack) state_d = StCmdColLo;
            StCmdColLo: if (op_ack) state_d = StCmdColHi;
            StCmdColHi: if (op_ack) state_d = StRd;
            StRd:       if (op_ack) state_d = StWr;
            StWr: begin
                if (op_ack) begin
                    if (col_q < LastCol) begin
                        col_d   = col_q + 8'd1;
                        state_d = StRd;
                    end else begin
                        col_d = 8'd0;
                        if (page_q == LastPage) begin
                            page_d  = 3'd0;
                            state_d = StDone;
                        end else begin
                            page_d  = page_q + 3'd1;
                            state_d = StCmdPage;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk_ce) begin
            if (reset) begin
                state_q <= StIdle;
                page_q  <= 3'd0;
                col_q   <= 8'd0;
                byte_q  <= 8'h00;
            end else begin
                state_q <= state_d;
                page_q  <= page_d;
                col_q   <= col_d;
                if (op_assert && !op_wr) begin
                    byte_q <= data_in;
                end
            end
        end
    end

    bus_strobe_gen u_strobe (
        .clk_i       (clk),
        .ce_i        (clk_ce),
        .rst_i       (reset),
        .req_i       (op_req),
        .wr_i        (op_wr),
        .addr_i      (op_addr),
        .wdata_i     (op_data),
        .grant_i     (bus_grant),
        .assert_o    (op_assert),
        .ack_o       (op_ack),
        .bus_write_o (bus_write),
        .bus_read_o  (bus_read),
        .addr_o      (address_out),
        .wdata_o     (data_out)
    );

    assign bus_request = op_req || (state_q == StReq);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_prc_lcd_copier.sv
// Directed bench for prc_lcd_copier: RAM and LCD models on the bus, an expected write/read
// sequence generated from the framebuffer pattern, and a ce-cycle monitor.
module tb_prc_lcd_copier;

    localparam int WrPerFrame = 8 * (3 + 96);
    localparam int RdPerFrame = 8 * 96;

    logic        clk, reset, clk_ce, start, bus_grant;
    logic        bus_request, bus_write, bus_read, busy, done;
    logic [23:0] address_out;
    logic [7:0]  data_out, data_in;

    logic [7:0]  fb  [0:767];
    logic [7:0]  lcd [0:8*132-1];
    logic [23:0] fb_off;

    int n_tests, n_fail;
    int ce_div, ce_ph;
    int clk_cnt, req_clk, done_clk, gap;
    int wr_cnt, rd_cnt, seq_err, viol, nogrant, done_cnt;
    int lcd_page, lcd_col;
    logic [7:0] first_wr;
    bit prev_strobe, prev_req;

    prc_lcd_copier dut (
        .clk         (clk),
        .reset       (reset),
        .clk_ce      (clk_ce),
        .start       (start),
        .bus_grant   (bus_grant),
        .bus_request (bus_request),
        .bus_write   (bus_write),
        .bus_read    (bus_read),
        .address_out (address_out),
        .data_out    (data_out),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM returns framebuffer bytes combinationally during a read strobe, garbage otherwise.
    assign fb_off  = address_out - 24'h001000;
    assign data_in = (bus_read && address_out >= 24'h001000 && fb_off < 24'd768) ?
                     fb[fb_off[9:0]] : 8'hEE;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected i-th bus write of a frame.
    task automatic exp_write(input int i, output logic [23:0] a, output logic [7:0] d);
        int p, k;
        p = (i % WrPerFrame) / 99;
        k = (i % WrPerFrame) % 99;
        if (k == 0) begin
            a = 24'h0020FE; d = 8'hB0 | 8'(p);
        end else if (k == 1) begin
            a = 24'h0020FE; d = 8'h00;
        end else if (k == 2) begin
            a = 24'h0020FE; d = 8'h10;
        end else begin
            a = 24'h0020FF; d = 8'((p * 96 + k - 3) & 8'hFF);
        end
    endtask

    task automatic clear_monitor();
        wr_cnt = 0; rd_cnt = 0; seq_err = 0; viol = 0; nogrant = 0; done_cnt = 0;
        first_wr = 8'h00;
        for (int i = 0; i < 8 * 132; i++) lcd[i] = 8'h5A;
        for (int i = 0; i < 768; i++) lcd[(i / 96) * 132 + (i % 96)] = ~fb[i];
    endtask

    // Clock-enable generator: high one clk out of every ce_div.
    initial begin
        clk_ce = 1'b1;
        ce_ph  = 0;
        forever begin
            @(posedge clk);
            #1;
            ce_ph  = (ce_ph + 1 >= ce_div) ? 0 : ce_ph + 1;
            clk_ce = (ce_ph == 0);
        end
    end

    // Bus monitor sampled mid-cycle on ce cycles only.
    initial begin
        logic [23:0] ea;
        logic [7:0]  ed;
        clk_cnt = 0; prev_strobe = 0; prev_req = 0; done_clk = 0; req_clk = 0; gap = 0;
        lcd_page = 0; lcd_col = 0;
        forever begin
            @(negedge clk);
            clk_cnt++;
            if (clk_ce) begin
                if (bus_write && bus_read) viol++;
                if ((bus_write || bus_read) && prev_strobe) viol++;
                prev_strobe = bus_write || bus_read;
                if ((bus_write || bus_read) && !bus_grant) nogrant++;
                if (bus_request && !prev_req) begin
                    req_clk = clk_cnt;
                    gap     = clk_cnt - done_clk;
                end
                prev_req = bus_request;
                if (done) begin
                    done_cnt++;
                    done_clk = clk_cnt;
                end
                if (bus_write) begin
                    exp_write(wr_cnt, ea, ed);
                    if (address_out !== ea || data_out !== ed) seq_err++;
                    if (wr_cnt == 0) first_wr = data_out;
                    if (address_out == 24'h0020FE) begin
                        if (data_out[7:4] == 4'hB) lcd_page = int'(data_out[2:0]);
                        else if (data_out[7:4] == 4'h0) lcd_col = (lcd_col & 8'hF0) | int'(data_out[3:0]);
                        else if (data_out[7:4] == 4'h1) lcd_col = (lcd_col & 8'h0F) | (int'(data_out[3:0]) << 4);
                    end else if (address_out == 24'h0020FF) begin
                        if (lcd_col < 132) lcd[lcd_page * 132 + lcd_col] = data_out;
                        lcd_col++;
                    end
                    wr_cnt++;
                end
                if (bus_read) begin
                    if (address_out !== 24'h001000 + 24'(rd_cnt % RdPerFrame)) seq_err++;
                    rd_cnt++;
                end
            end
        end
    end

    task automatic check_lcd(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < 768; i++)
            if (lcd[(i / 96) * 132 + (i % 96)] !== fb[i]) errs++;
        check_eq(tag, errs, 0);
    endtask

    task automatic run_frame(input int div, input bit drop, input bit extra_starts,
                             input string tag);
        clear_monitor();
        ce_div = div;
        @(posedge clk); #1;
        start = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) begin @(posedge clk); #1; end
        start = 1'b0;
        if (drop) begin
            for (int i = 0; i < 5000 && wr_cnt < 340; i++) @(posedge clk);
            #1 bus_grant = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            check_eq({tag, "_hold_addr"}, address_out, 24'h001000 + 3 * 96 + 40);
            check_eq({tag, "_hold_req"}, bus_request, 1);
            check_eq({tag, "_hold_strobe"}, {bus_write, bus_read}, 2'b00);
            check_eq({tag, "_hold_rd_cnt"}, rd_cnt, 328);
            check_eq({tag, "_hold_wr_cnt"}, wr_cnt, 340);
            bus_grant = 1'b1;
        end
        if (extra_starts) begin
            for (int k = 0; k < 3; k++) begin
                repeat (50) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        for (int i = 0; i < 4000 * div && done_cnt < 1; i++) @(posedge clk);
        check_eq({tag, "_done_seen"}, done_cnt, 1);
        if (!drop) check_eq({tag, "_done_latency"}, done_clk - req_clk, 3121 * div);
        repeat (20 * div) @(posedge clk);
        #1;
        check_eq({tag, "_idle_after"}, {busy, bus_request}, 2'b00);
        check_eq({tag, "_one_done"}, done_cnt, 1);
        check_eq({tag, "_sequence"}, seq_err, 0);
        check_eq({tag, "_wr_count"}, wr_cnt, WrPerFrame);
        check_eq({tag, "_rd_count"}, rd_cnt, RdPerFrame);
        check_eq({tag, "_first_wr"}, first_wr, 8'hB0);
        check_eq({tag, "_spacing"}, viol, 0);
        check_eq({tag, "_nogrant_strobe"}, nogrant, 0);
        check_lcd({tag, "_lcd"});
    endtask

    initial begin
        n_tests = 0; n_fail = 0; ce_div = 1;
        for (int i = 0; i < 768; i++) fb[i] = 8'(i & 8'hFF);
        reset = 1'b1; start = 1'b0; bus_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_req", bus_request, 0);
        check_eq("rst_strobes", {bus_write, bus_read}, 2'b00);
        check_eq("rst_addr", address_out, 24'h000000);
        check_eq("rst_data", data_out, 8'h00);

        run_frame(1, 1'b0, 1'b1, "frame");
        run_frame(1, 1'b1, 1'b0, "grant_drop");
        run_frame(3, 1'b0, 1'b0, "ce_div3");

        // Reset in the middle of page 5.
        clear_monitor();
        ce_div = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5000 && wr_cnt < 508; i++) @(posedge clk);
        check_eq("midrst_reached", wr_cnt, 508);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_req", bus_request, 0);
        check_eq("midrst_strobes", {bus_write, bus_read}, 2'b00);
        check_eq("midrst_addr", address_out, 24'h000000);
        check_eq("midrst_data", data_out, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        check_eq("midrst_no_done", done_cnt, 0);
        check_eq("midrst_stays_idle", busy, 0);
        run_frame(1, 1'b0, 1'b0, "restart");

        // start held high: exactly two frames, one IDLE cycle plus REQ between them.
        clear_monitor();
        @(posedge clk); #1 start = 1'b1;
        for (int i = 0; i < 8000 && done_cnt < 2; i++) @(posedge clk);
        #1 start = 1'b0;
        check_eq("b2b_two_done", done_cnt, 2);
        check_eq("b2b_gap", gap, 2);
        repeat (20) @(posedge clk);
        #1;
        check_eq("b2b_no_third", {busy, 8'(done_cnt)}, {1'b0, 8'd2});
        check_eq("b2b_sequence", seq_err, 0);
        check_eq("b2b_wr_count", wr_cnt, 2 * WrPerFrame);
        check_eq("b2b_spacing", viol, 0);
        check_lcd("b2b_lcd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
